mem_ctrl: RTL and testbench
===========================

# mem_ctrl

Memory controller sitting directly upstream of the data RAM: accepts read requests from the instruction-fetch port and read/write requests from the load/store port, arbitrates between them, and drives the RAM's separate read/write address, enable and write-data pins. It guarantees the RAM never sees `rd_en` and `wr_en` together, accounts for the RAM's one-cycle registered read, and returns a one-cycle acknowledge with read data to the winning requester.

## Interface
- `BUS_WIDTH`, from params.svh (8): address width, passed through to RAM.
- `DATA_WIDTH`, from params.svh (8): data width.
- `clk`  in  1  single system clock, rising edge.
- `rst`  in  1  reset; synchronous, active-high.
- `f_req`  in  1  fetch read request, level.
- `f_addr`  in  BUS_WIDTH  fetch address.
- `f_ack`  out  1  fetch acknowledge, one-cycle pulse.
- `f_rdata`  out  DATA_WIDTH  fetch read data, valid while `f_ack`=1, else 0.
- `d_req`  in  1  data request, level.
- `d_we`  in  1  1 = store, 0 = load.
- `d_addr`  in  BUS_WIDTH  data address.
- `d_wdata`  in  DATA_WIDTH  store data.
- `d_ack`  out  1  data acknowledge, one-cycle pulse.
- `d_rdata`  out  DATA_WIDTH  load data, valid while `d_ack`=1 and load, else 0.
- `busy`  out  1  1 in any state other than IDLE.
- `ram_addr_rd`, `ram_addr_wr`  out  BUS_WIDTH  RAM addresses.
- `ram_data_wr`  out  DATA_WIDTH  RAM write data.
- `ram_rd_en`, `ram_wr_en`  out  1  RAM strobes; never both 1.
- `ram_data_rd`  in  DATA_WIDTH  RAM registered read data.

## Operation
- States: IDLE, RD, WR, ACK.
- IDLE: sample `f_req`/`d_req` at the clock edge. Winner's address, `d_we`, `d_wdata` and grant ID are latched into internal registers. Load or fetch goes to RD; store goes to WR. No request keeps the FSM in IDLE.
- Arbitration (default): `d_req` beats `f_req`. Stall of fetch behind an unbroken data stream is accepted.
- RD: `ram_rd_en`=1 and `ram_addr_rd`=latched address for exactly one cycle, then ACK.
- WR: `ram_wr_en`=1 with `ram_addr_wr`/`ram_data_wr` from latched registers for exactly one cycle, then ACK.
- ACK: assert winner's ack. For reads, the winner's rdata = `ram_data_rd` (combinational pass-through, gated to 0 otherwise). The FSM always returns to IDLE.
- Strobes are decoded from registered state only: glitch-free, never both high.
- RAM address/data outputs hold the last latched values outside RD/WR.
- Requester holds req and operands stable until it sees ack. If req is still high in the IDLE following ACK, that is a new transaction (back-to-back allowed).
- Inputs changed mid-transaction are ignored: operands come from latched registers.

## Timing
- Reset: state IDLE; all outputs 0, including RAM addresses/data, `f_rdata`, `d_rdata` and `busy`. The round-robin pointer favours data.
- Reset mid-transaction: transaction is abandoned and no ack is issued. A strobe drops in the cycle after the reset edge; a store in WR may or may not have landed.
- Latency: a request sampled at edge k puts the strobe in cycle k..k+1 and the ack in cycle k+1..k+2. Each transaction occupies 3 cycles.
- Peak throughput: one transaction per 3 cycles.
- Simultaneous `f_req` and `d_req` in IDLE: one grant; the loser stays pending and is sampled again at the next IDLE edge.
- Address wrap: none; addresses pass through unmodified.

## Configuration
- `MEM_CTRL_RR_EN` defined: round-robin arbitration.
  - A 1-bit pointer toggles after each granted transaction when both ports requested.
  - On simultaneous requests, the port not served last wins.
- `MEM_CTRL_RR_EN` undefined: fixed data-over-fetch priority and no pointer flop.

## Structure
- Add to params.svh (shared): `mem_state_t` enum (IDLE, RD, WR, ACK) and `mem_grant_t` enum (GNT_F, GNT_D).
- Sub-module `mem_arb`: 2-way arbiter containing the `MEM_CTRL_RR_EN` pointer. Inputs `clk`, `rst`, `f_req`, `d_req`, `advance`; output `mem_grant_t`.
- FSM, operand latches and RAM-side decode live in `mem_ctrl`.

## Test plan
- Store then load: `d_req`, `d_we`=1, addr 0x03, data 0xA5; then load 0x03 → `ram_wr_en` one cycle, `d_ack` 2 cycles after accept, load `d_ack` with `d_rdata`=0xA5, `ram_rd_en`·`ram_wr_en` never 1.
- Fetch: RAM preloaded 0x10=0x3C, `f_req` addr 0x10 → `f_ack` one cycle, `f_rdata`=0x3C, `d_ack`=0 throughout.
- Contention: `f_req` and `d_req` both high at same edge → fixed: `d_ack` first, `f_ack` 3 cycles later; `MEM_CTRL_RR_EN`: second contention is granted to the opposite port.
- Back-to-back: `d_req` held high for 3 loads with changing address → 3 `d_ack` pulses spaced exactly 3 cycles.
- Operand stability: `d_addr` changed from 0x04 to 0x07 during RD → data returned from 0x04.
- Reset in WR: assert `rst` during the WR cycle → no `d_ack`, all outputs 0 after the edge, `busy`=0, next request serviced normally.

Source files
------------

// File: rtl/mem_ctrl_pkg.sv
// mem_ctrl_pkg: types and default widths shared by the memory controller.
//   MEM_BUS_WIDTH  - default address width (8)
//   MEM_DATA_WIDTH - default data width (8)
//   mem_state_t    - controller FSM states
//   mem_grant_t    - arbiter grant identifier
// Optional build macro used by this slice: MEM_CTRL_RR_EN (see mem_arb).
package mem_ctrl_pkg;

  localparam int MEM_BUS_WIDTH  = 8;
  localparam int MEM_DATA_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2,
    ACK  = 2'd3
  } mem_state_t;

  typedef enum logic {
    GNT_F = 1'b0,
    GNT_D = 1'b1
  } mem_grant_t;

endpackage

// File: rtl/mem_arb.sv
// mem_arb: 2-way arbiter between the fetch port and the load/store port.
// Ports:
//   clk, rst  - clock, synchronous active-high reset
//   f_req     - fetch request
//   d_req     - data request
//   advance   - a grant is being taken this cycle
//   grant     - winning port (combinational from requests and pointer)
// Build macro MEM_CTRL_RR_EN:
//   defined   - round-robin; the pointer flips after each contended grant so
//               the port not served last wins the next contention
//   undefined - fixed data-over-fetch priority, no pointer flop
module mem_arb
  import mem_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       f_req,
  input  logic       d_req,
  input  logic       advance,
  output mem_grant_t grant
);

`ifdef MEM_CTRL_RR_EN
  // Port that wins the next contention; data is favoured out of reset.
  mem_grant_t favour_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      favour_reg <= GNT_D;
    end else if (advance && f_req && d_req) begin
      // The favoured port just won, so hand preference to the other one.
      favour_reg <= mem_grant_t'(~favour_reg);
    end
  end

  always_comb begin
    grant = GNT_F;
    if (f_req && d_req) begin
      grant = favour_reg;
    end else if (d_req) begin
      grant = GNT_D;
    end
  end
`else
  // Fixed priority needs neither the clock nor the advance strobe.
  logic unused_ok;
  assign unused_ok = ^{clk, rst, advance, f_req};

  always_comb begin
    grant = d_req ? GNT_D : GNT_F;
  end
`endif

endmodule

// File: rtl/mem_ctrl.sv
// mem_ctrl: memory controller in front of a data RAM with a registered read.
// Arbitrates fetch reads against load/store requests, runs one RAM access per
// transaction (IDLE -> RD/WR -> ACK -> IDLE, 3 cycles) and returns a
// one-cycle ack with read data to the winner.
// Ports:
//   clk, rst                    - clock, synchronous active-high reset
//   f_req/f_addr/f_ack/f_rdata  - fetch port
//   d_req/d_we/d_addr/d_wdata   - load/store request
//   d_ack/d_rdata               - load/store response
//   busy                        - controller not in IDLE
//   ram_addr_rd/ram_addr_wr     - RAM addresses (last latched address)
//   ram_data_wr                 - RAM write data (last latched store data)
//   ram_rd_en/ram_wr_en         - RAM strobes, mutually exclusive
//   ram_data_rd                 - RAM registered read data
// Build macro MEM_CTRL_RR_EN selects round-robin arbitration in mem_arb.
module mem_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int BUS_WIDTH  = MEM_BUS_WIDTH,
  parameter int DATA_WIDTH = MEM_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  f_req,
  input  logic [BUS_WIDTH-1:0]  f_addr,
  output logic                  f_ack,
  output logic [DATA_WIDTH-1:0] f_rdata,
  input  logic                  d_req,
  input  logic                  d_we,
  input  logic [BUS_WIDTH-1:0]  d_addr,
  input  logic [DATA_WIDTH-1:0] d_wdata,
  output logic                  d_ack,
  output logic [DATA_WIDTH-1:0] d_rdata,
  output logic                  busy,
  output logic [BUS_WIDTH-1:0]  ram_addr_rd,
  output logic [BUS_WIDTH-1:0]  ram_addr_wr,
  output logic [DATA_WIDTH-1:0] ram_data_wr,
  output logic                  ram_rd_en,
  output logic                  ram_wr_en,
  input  logic [DATA_WIDTH-1:0] ram_data_rd
);

  mem_state_t            state_reg;
  mem_grant_t            gnt_reg;
  mem_grant_t            grant;
  logic                  we_reg;
  logic [BUS_WIDTH-1:0]  addr_reg;
  logic [DATA_WIDTH-1:0] wdata_reg;
  logic                  advance;

  assign advance = (state_reg == IDLE) && (f_req || d_req);

  mem_arb u_arb (
    .clk     (clk),
    .rst     (rst),
    .f_req   (f_req),
    .d_req   (d_req),
    .advance (advance),
    .grant   (grant)
  );

  // Operands are captured only at the accepting edge, so requester inputs
  // may change freely while a transaction is in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      gnt_reg   <= GNT_F;
      we_reg    <= 1'b0;
      addr_reg  <= '0;
      wdata_reg <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (advance) begin
            gnt_reg <= grant;
            if (grant == GNT_D) begin
              addr_reg  <= d_addr;
              we_reg    <= d_we;
              wdata_reg <= d_wdata;
              state_reg <= d_we ? WR : RD;
            end else begin
              addr_reg  <= f_addr;
              we_reg    <= 1'b0;
              state_reg <= RD;
            end
          end
        end
        RD:      state_reg <= ACK;
        WR:      state_reg <= ACK;
        ACK:     state_reg <= IDLE;
        default: state_reg <= IDLE;
      endcase
    end
  end

  // Everything below is a decode of registers only, so the strobes cannot
  // glitch and RD/WR being distinct states keeps them exclusive.
  assign busy        = (state_reg != IDLE);
  assign ram_rd_en   = (state_reg == RD);
  assign ram_wr_en   = (state_reg == WR);
  assign ram_addr_rd = addr_reg;
  assign ram_addr_wr = addr_reg;
  assign ram_data_wr = wdata_reg;

  // The RAM registers its read at the RD->ACK edge, so its output is valid
  // throughout ACK and can be passed straight to the winner.
  assign f_ack   = (state_reg == ACK) && (gnt_reg == GNT_F);
  assign d_ack   = (state_reg == ACK) && (gnt_reg == GNT_D);
  assign f_rdata = f_ack ? ram_data_rd : '0;
  assign d_rdata = (d_ack && !we_reg) ? ram_data_rd : '0;

endmodule

// File: tb/tb_mem_ctrl.sv
// tb_mem_ctrl: self-checking bench for mem_ctrl.
// A transaction-level model (accept edge, one strobe cycle, one ack cycle,
// shadow memory) predicts every output each cycle; directed sequences add
// hand-computed expectations for data values and ack timing.
// Honours MEM_CTRL_RR_EN for the arbitration rule.
module tb_mem_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       f_req, d_req, d_we;
  logic [7:0] f_addr, d_addr, d_wdata;
  logic       f_ack, d_ack, busy, ram_rd_en, ram_wr_en;
  logic [7:0] f_rdata, d_rdata, ram_addr_rd, ram_addr_wr, ram_data_wr;
  logic [7:0] ram_data_rd = '0;

  always #5 clk = ~clk;

  mem_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .f_req       (f_req),
    .f_addr      (f_addr),
    .f_ack       (f_ack),
    .f_rdata     (f_rdata),
    .d_req       (d_req),
    .d_we        (d_we),
    .d_addr      (d_addr),
    .d_wdata     (d_wdata),
    .d_ack       (d_ack),
    .d_rdata     (d_rdata),
    .busy        (busy),
    .ram_addr_rd (ram_addr_rd),
    .ram_addr_wr (ram_addr_wr),
    .ram_data_wr (ram_data_wr),
    .ram_rd_en   (ram_rd_en),
    .ram_wr_en   (ram_wr_en),
    .ram_data_rd (ram_data_rd)
  );

  // RAM with registered read, as seen by the controller.
  logic [7:0] ram [256];
  always @(posedge clk) begin
    if (ram_wr_en) ram[ram_addr_wr] <= ram_data_wr;
    if (ram_rd_en) ram_data_rd <= ram[ram_addr_rd];
  end

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- transaction-level model ----------------
  // m_age: 0 = no transaction, 1 = RAM access cycle, 2 = acknowledge cycle.
  logic [7:0] shadow [256];
  int         m_age = 0;
  bit         m_live = 1'b0;
  bit         m_port_d, m_we, m_favour_d;
  logic [7:0] m_addr, m_wdata;
  int         txn = 0;

  always @(posedge clk) begin
    cyc = cyc + 1;
    // A store strobe at this edge lands in the RAM, reset or not.
    if (m_age == 1 && m_we) shadow[m_addr] = m_wdata;
    if (rst) begin
      m_age = 0; m_addr = '0; m_wdata = '0; m_we = 1'b0;
      m_port_d = 1'b0; m_favour_d = 1'b1; m_live = 1'b1;
    end else if (m_age == 1) begin
      m_age = 2;
    end else if (m_age == 2) begin
      m_age = 0;
    end else if (f_req || d_req) begin
      bit win_d;
`ifdef MEM_CTRL_RR_EN
      if (f_req && d_req) begin
        win_d      = m_favour_d;
        m_favour_d = !m_favour_d;
      end else begin
        win_d = d_req;
      end
`else
      win_d = d_req;
`endif
      m_port_d = win_d;
      m_age    = 1;
      if (win_d) begin
        m_addr = d_addr; m_we = d_we; m_wdata = d_wdata;
      end else begin
        m_addr = f_addr; m_we = 1'b0;
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  logic       e_fack, e_dack;
  logic [7:0] e_rd;
  always @(negedge clk) begin
    if (m_live) begin
      e_fack = (m_age == 2) && !m_port_d;
      e_dack = (m_age == 2) && m_port_d;
      e_rd   = shadow[m_addr];
      check("busy",        busy,        m_age != 0);
      check("ram_rd_en",   ram_rd_en,   (m_age == 1) && !m_we);
      check("ram_wr_en",   ram_wr_en,   (m_age == 1) && m_we);
      check("ram_addr_rd", ram_addr_rd, m_addr);
      check("ram_addr_wr", ram_addr_wr, m_addr);
      check("ram_data_wr", ram_data_wr, m_wdata);
      check("f_ack",       f_ack,       e_fack);
      check("d_ack",       d_ack,       e_dack);
      check("f_rdata",     f_rdata,     e_fack ? e_rd : 8'h00);
      check("d_rdata",     d_rdata,     (e_dack && !m_we) ? e_rd : 8'h00);
      check("strobe_excl", ram_rd_en & ram_wr_en, 1'b0);
      if (e_fack || e_dack) begin
        txn++;
        $display("txn %0d: cycle=%0d port=%s we=%0d addr=%02h f_rdata=%02h d_rdata=%02h",
                 txn, cyc, m_port_d ? "D" : "F", m_we, m_addr, f_rdata, d_rdata);
      end
    end
  end

  // ---------------- directed helpers ----------------
  // Caller is at a negedge; one idle cycle is left before driving.
  task automatic do_req(input bit is_d, input bit we, input logic [7:0] addr,
                        input logic [7:0] wdata, output logic [7:0] rdata, output int lat);
    int drv;
    bit seen;
    @(negedge clk);
    drv = cyc; seen = 1'b0; rdata = '0; lat = -1;
    if (is_d) begin
      d_req = 1'b1; d_we = we; d_addr = addr; d_wdata = wdata;
    end else begin
      f_req = 1'b1; f_addr = addr;
    end
    for (int i = 0; i < 12 && !seen; i++) begin
      @(negedge clk);
      if (is_d ? d_ack : f_ack) begin
        seen  = 1'b1;
        lat   = cyc - drv;
        rdata = is_d ? d_rdata : f_rdata;
      end
    end
    if (is_d) d_req = 1'b0; else f_req = 1'b0;
    check("ack_seen", seen, 1'b1);
  endtask

  // Both ports request at the same edge; returns ack cycles relative to drive.
  task automatic contend(output int d_at, output int f_at);
    int drv;
    bit ds, fs;
    @(negedge clk);
    drv = cyc; ds = 1'b0; fs = 1'b0; d_at = -1; f_at = -1;
    f_req = 1'b1; f_addr = 8'h10;
    d_req = 1'b1; d_we = 1'b0; d_addr = 8'h03;
    for (int i = 0; i < 15 && !(ds && fs); i++) begin
      @(negedge clk);
      if (d_ack && !ds) begin ds = 1'b1; d_at = cyc - drv; d_req = 1'b0; end
      if (f_ack && !fs) begin fs = 1'b1; f_at = cyc - drv; f_req = 1'b0; end
    end
    f_req = 1'b0; d_req = 1'b0;
    check("contend_done", ds && fs, 1'b1);
  endtask

  // ---------------- directed sequence ----------------
  logic [7:0] rd;
  int         lat, d_at, f_at;
  int         ack_cyc [3];
  logic [7:0] ack_dat [3];
  bit         saw;

  initial begin
    for (int i = 0; i < 256; i++) begin
      ram[i] = 8'h00; shadow[i] = 8'h00;
    end
    ram[8'h10] = 8'h3C; shadow[8'h10] = 8'h3C;
    ram[8'h04] = 8'h11; shadow[8'h04] = 8'h11;
    ram[8'h07] = 8'h77; shadow[8'h07] = 8'h77;

    rst = 1'b1; f_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
    f_addr = '0; d_addr = '0; d_wdata = '0;
    repeat (2) @(negedge clk);
    check("rst_busy",    busy,        1'b0);
    check("rst_addr_rd", ram_addr_rd, 8'h00);
    check("rst_f_rdata", f_rdata,     8'h00);
    rst = 1'b0;

    // Store 0xA5 to 0x03, then load it back.
    do_req(1'b1, 1'b1, 8'h03, 8'hA5, rd, lat);
    check("store_lat", lat, 2);
    do_req(1'b1, 1'b0, 8'h03, 8'h00, rd, lat);
    check("load_lat", lat, 2);
    check("load_data", rd, 8'hA5);

    // Fetch from preloaded 0x10.
    do_req(1'b0, 1'b0, 8'h10, 8'h00, rd, lat);
    check("fetch_lat", lat, 2);
    check("fetch_data", rd, 8'h3C);

    // First contention: data favoured in both builds.
    contend(d_at, f_at);
    check("cont1_d_at", d_at, 2);
    check("cont1_f_at", f_at, 5);

    // Second contention: round-robin hands it to fetch.
    contend(d_at, f_at);
`ifdef MEM_CTRL_RR_EN
    check("cont2_f_at", f_at, 2);
    check("cont2_d_at", d_at, 5);
`else
    check("cont2_d_at", d_at, 2);
    check("cont2_f_at", f_at, 5);
`endif

    // Back-to-back loads with d_req held high.
    @(negedge clk);
    d_req = 1'b1; d_we = 1'b0; d_addr = 8'h10;
    begin
      int n = 0;
      for (int i = 0; i < 20 && n < 3; i++) begin
        @(negedge clk);
        if (d_ack) begin
          ack_cyc[n] = cyc; ack_dat[n] = d_rdata; n++;
          d_addr = (n == 1) ? 8'h03 : 8'h04;
        end
      end
      d_req = 1'b0;
      check("b2b_count", n, 3);
    end
    check("b2b_gap1", ack_cyc[1] - ack_cyc[0], 3);
    check("b2b_gap2", ack_cyc[2] - ack_cyc[1], 3);
    check("b2b_dat0", ack_dat[0], 8'h3C);
    check("b2b_dat1", ack_dat[1], 8'hA5);
    check("b2b_dat2", ack_dat[2], 8'h11);

    // Address changes from 0x04 to 0x07 while the read is in flight.
    @(negedge clk);
    d_req = 1'b1; d_we = 1'b0; d_addr = 8'h04;
    @(negedge clk);
    check("stab_rd_en", ram_rd_en, 1'b1);
    d_addr = 8'h07;
    saw = 1'b0; rd = '0;
    for (int i = 0; i < 8 && !saw; i++) begin
      @(negedge clk);
      if (d_ack) begin saw = 1'b1; rd = d_rdata; end
    end
    d_req = 1'b0;
    check("stab_ack", saw, 1'b1);
    check("stab_data", rd, 8'h11);

    // Reset during the write strobe.
    @(negedge clk);
    d_req = 1'b1; d_we = 1'b1; d_addr = 8'h20; d_wdata = 8'h5A;
    saw = 1'b0;
    for (int i = 0; i < 5 && !saw; i++) begin
      @(negedge clk);
      if (ram_wr_en) saw = 1'b1;
    end
    check("wr_seen", saw, 1'b1);
    rst = 1'b1; d_req = 1'b0;
    @(negedge clk);
    check("rstwr_busy",    busy,        1'b0);
    check("rstwr_wr_en",   ram_wr_en,   1'b0);
    check("rstwr_addr_wr", ram_addr_wr, 8'h00);
    check("rstwr_data_wr", ram_data_wr, 8'h00);
    check("rstwr_d_ack",   d_ack,       1'b0);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    do_req(1'b0, 1'b0, 8'h10, 8'h00, rd, lat);
    check("post_rst_lat",  lat, 2);
    check("post_rst_data", rd,  8'h3C);

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
